// File: rtl/leading_one_onehot_pipe.sv
// leading_one_onehot_pipe: 2-stage valid/ready leading-one isolator producing split 16-bit one-hot halves plus zero flag
module leading_one_onehot_pipe #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] g_onehot,
  output logic [15:0] e_onehot,
  output logic        out_zero
);
  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction
  function automatic logic [15:0] isolate(input logic [15:0] x);
    logic [15:0] r;
    r = MSB_FIRST ? rev16(x) : x;
    r = r & ~(r - 16'd1);
    return MSB_FIRST ? rev16(r) : r;
  endfunction
  logic        s1_valid, s2_valid, s2_accept;
  logic [15:0] lo_oh, hi_oh;
  logic        lo_nz, hi_nz;
  assign s2_accept = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_accept;
  assign out_valid = s2_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      lo_oh    <= '0;
      hi_oh    <= '0;
      lo_nz    <= 1'b0;
      hi_nz    <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      lo_oh    <= isolate(in_data[15:0]);
      hi_oh    <= isolate(in_data[31:16]);
      lo_nz    <= |in_data[15:0];
      hi_nz    <= |in_data[31:16];
    end else if (s2_accept) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      g_onehot <= '0;
      e_onehot <= '0;
      out_zero <= 1'b0;
    end else if (s1_valid && s2_accept) begin
      s2_valid <= 1'b1;
      e_onehot <= MSB_FIRST ? hi_oh : (lo_nz ? 16'd0 : hi_oh);
      g_onehot <= MSB_FIRST ? (hi_nz ? 16'd0 : lo_oh) : lo_oh;
      out_zero <= !(hi_nz || lo_nz);
    end else if (s2_accept) begin
      s2_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_leading_one_onehot_pipe.sv
// tb_leading_one_onehot_pipe: directed self-checking bench for both MSB_FIRST settings
module tb_leading_one_onehot_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        m_in_ready, m_out_valid, m_z;
  logic        l_in_ready, l_out_valid, l_z;
  logic [15:0] m_g, m_e, l_g, l_e;
  int          checks = 0;
  int          errors = 0;
  leading_one_onehot_pipe #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .g_onehot(m_g), .e_onehot(m_e), .out_zero(m_z)
  );
  leading_one_onehot_pipe #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .g_onehot(l_g), .e_onehot(l_e), .out_zero(l_z)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic int pos16(input logic [15:0] x);
    for (int i = 0; i < 16; i++) if (x[i]) return i;
    return -1;
  endfunction
  function automatic int enc(input logic [15:0] e, input logic [15:0] g);
    return (e != 16'd0) ? 16 + pos16(e) : pos16(g);
  endfunction
  task automatic one_word(input string tag, input logic [31:0] d, input logic [15:0] me, input logic [15:0] mg,
                          input logic [15:0] le, input logic [15:0] lg, input logic z);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1 chk({tag, "_in_ready"}, 32'(m_in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_early_valid"}, 32'(m_out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(m_out_valid), 32'd1);
    chk({tag, "_msb_e"}, 32'(m_e), 32'(me));
    chk({tag, "_msb_g"}, 32'(m_g), 32'(mg));
    chk({tag, "_lsb_e"}, 32'(l_e), 32'(le));
    chk({tag, "_lsb_g"}, 32'(l_g), 32'(lg));
    chk({tag, "_msb_zero"}, 32'(m_z), 32'(z));
    chk({tag, "_lsb_zero"}, 32'(l_z), 32'(z));
  endtask
  task automatic stream(input bit rnd);
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    bit fin = 0;
    bit fout = 0;
    bit stall = 0;
    logic [15:0] pe = '0;
    logic [15:0] pg = '0;
    while (rcvd < 32 && cyc < 400) begin
      @(negedge clk);
      if (fin) sent++;
      if (fout) rcvd++;
      if (stall) begin
        chk("hold_valid", 32'(m_out_valid), 32'd1);
        chk("hold_e", 32'(m_e), 32'(pe));
        chk("hold_g", 32'(m_g), 32'(pg));
      end
      if (m_out_valid) begin
        chk("msb_index", 32'(enc(m_e, m_g)), 32'(rcvd));
        chk("lsb_index", 32'(enc(l_e, l_g)), 32'(rcvd));
        chk("stream_zero", 32'(m_z), 32'd0);
      end
      if (!rnd && rcvd > 0 && rcvd < 32) chk("back_to_back", 32'(m_out_valid), 32'd1);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = sent < 32;
      in_data   = 32'd1 << sent;
      #1;
      chk("stream_in_ready", 32'(m_in_ready), 32'(!((sent - rcvd == 2) && !out_ready)));
      fin   = in_valid && m_in_ready;
      fout  = m_out_valid && out_ready;
      stall = m_out_valid && !out_ready;
      pe    = m_e;
      pg    = m_g;
      cyc++;
    end
    chk("stream_count", 32'(rcvd), 32'd32);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #12;
    chk("rst_valid", 32'(m_out_valid), 32'd0);
    chk("rst_g", 32'(m_g), 32'd0);
    chk("rst_e", 32'(m_e), 32'd0);
    chk("rst_zero", 32'(m_z), 32'd0);
    chk("rst_in_ready", 32'(l_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    one_word("top", 32'h8000_0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0);
    one_word("mixed", 32'h0001_2345, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b0);
    one_word("zero", 32'h0000_0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    one_word("bit6", 32'h0000_0040, 16'h0000, 16'h0040, 16'h0000, 16'h0040, 1'b0);
    one_word("hi_full", 32'hFFFF_0000, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 1'b0);
    one_word("lo_full", 32'h0000_FFFF, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 1'b0);
    stream(1'b0);
    stream(1'b1);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h0000_0100;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(m_out_valid), 32'd1);
    chk("pre_rst_g", 32'(m_g), 32'h0100);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(m_out_valid), 32'd0);
    chk("async_rst_g", 32'(m_g), 32'd0);
    chk("async_rst_e", 32'(m_e), 32'd0);
    chk("async_rst_zero", 32'(m_z), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 32'(m_in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", 32'(m_out_valid), 32'd0);
    end
    one_word("after_rst", 32'h0000_0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
